mixed_apb_cmd_master: RTL and testbench
=======================================

Name: mixed_apb_cmd_master

Overview:
- Upstream neighbour of the mixed block's APB target port; drives the flat cpu_main_* APB signals of the mixed HDL wrapper.
- Converts a valid/ready command channel (address, write data, direction) into a single APB transfer (SETUP then ACCESS).
- Returns read data and error status on a valid/ready response channel.
- Used by the bench stimulus layer and by any on-chip CPU-side agent; one outstanding transfer at a time.

Parameters:
- ADDR_W, 32, width of cmd_addr and cpu_main_paddr
- DATA_W, 32, width of cmd_wdata, rsp_rdata, cpu_main_pwdata, cpu_main_prdata
- TIMEOUT_CYCLES, 256, ACCESS-phase wait limit; used only when MIXED_APB_MASTER_TIMEOUT_EN is defined

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_W  target address
- cmd_wdata  input  DATA_W  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when high with rsp_valid
- rsp_rdata  output  DATA_W  read data (0 for writes)
- rsp_err  output  1  pslverr or timeout
- busy  output  1  high in any state except IDLE
- cpu_main_paddr  output  ADDR_W  APB address
- cpu_main_psel  output  1  APB select
- cpu_main_penable  output  1  APB enable
- cpu_main_pwrite  output  1  APB direction
- cpu_main_pwdata  output  DATA_W  APB write data
- cpu_main_pready  input  1  APB ready
- cpu_main_prdata  input  DATA_W  APB read data
- cpu_main_pslverr  input  1  APB slave error

Behaviour:
- Reset (async on rst_n low, released synchronously to clk):
  - State goes to IDLE.
  - All APB outputs are 0.
  - rsp_valid, rsp_rdata, rsp_err and busy are 0.
  - cmd_ready is 0 while rst_n is low.
  - Reset mid-transfer abandons the transfer silently; no response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs except cmd_ready are registered.
- IDLE:
  - cmd_ready = 1 (decoded from state).
  - On cmd_valid & cmd_ready, register cpu_main_paddr = cmd_addr, cpu_main_pwrite = cmd_write, and cpu_main_psel = 1.
  - cpu_main_pwdata = cmd_wdata for writes and 0 for reads.
  - Next state is SETUP.
- SETUP:
  - psel = 1, penable = 0 for exactly one cycle.
  - cpu_main_pready is ignored.
  - Next state is ACCESS, with penable = 1.
- ACCESS:
  - psel = 1 and penable = 1 until pready is sampled high.
  - On pready: capture rsp_rdata = prdata for reads (0 for writes) and rsp_err = pslverr.
  - On the same edge set rsp_valid = 1, drop psel and penable to 0, and go to RESP.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err hold stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid = 0 and next state is IDLE.
  - rsp_ready high in the same cycle rsp_valid rises completes the handshake at the next edge.
- Stability:
  - paddr, pwrite and pwdata are stable from SETUP through ACCESS completion.
  - After completion they keep their last values until the next accepted command.
- Latency:
  - Command accepted at edge 0; SETUP visible cycle 1; ACCESS visible cycle 2.
  - With pready = 1 in the first ACCESS cycle, rsp_valid is visible in cycle 3.
  - Each extra pready-low ACCESS cycle adds 1.
  - Back-to-back throughput is 4 cycles per transfer minimum (RESP then IDLE).
- No cmd_ready outside IDLE: cmd_valid during SETUP, ACCESS or RESP is held off, and command fields may change freely while cmd_ready = 0.
- busy = (state != IDLE).

Optional Feature:
- Macro: MIXED_APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES + 1) clears on entry to ACCESS and increments each ACCESS cycle with pready low.
  - When it reaches TIMEOUT_CYCLES with pready still low: drop psel/penable, set rsp_rdata = 0xDEADBEEF (truncated to DATA_W) and rsp_err = 1, and go to RESP.
  - If pready is high on that same cycle, the normal completion wins.
- Undefined:
  - No counter is present and ACCESS waits indefinitely.
  - TIMEOUT_CYCLES is unused.

Test Plan:
- Write, cmd_addr = 0x0000_0010, cmd_wdata = 0xA5A5_0001, pready = 1 in first ACCESS cycle -> psel high in cycles 1–2, penable only in cycle 2, pwdata = 0xA5A5_0001; rsp_valid in cycle 3 with rsp_rdata = 0, rsp_err = 0.
- Read at 0x0000_0020, pready low 3 ACCESS cycles then high with prdata = 0x1234_5678 -> paddr stable throughout; rsp_rdata = 0x1234_5678, rsp_valid in cycle 6.
- Read with pslverr = 1 on completion, rsp_ready held low 5 cycles -> rsp_err = 1; rsp held stable for 5 cycles; cmd_ready stays 0 until IDLE.
- Two back-to-back commands with cmd_valid held high and rsp_ready = 1 -> second SETUP starts exactly 4 cycles after the first; no APB overlap.
- rst_n asserted mid-ACCESS -> psel, penable and rsp_valid are 0 immediately (asynchronously); after release cmd_ready = 1 and no stale response.
- With MIXED_APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 8, pready held low -> abort after 8 ACCESS cycles; rsp_err = 1, rsp_rdata = 0xDEADBEEF.

Source files
------------

// File: rtl/mixed_apb_cmd_master.sv
// Valid/ready command to single APB transfer bridge, one transfer outstanding at a time.
// Optional ACCESS-phase timeout abort when MIXED_APB_MASTER_TIMEOUT_EN is defined.
module mixed_apb_cmd_master #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] cpu_main_paddr,
    output logic              cpu_main_psel,
    output logic              cpu_main_penable,
    output logic              cpu_main_pwrite,
    output logic [DATA_W-1:0] cpu_main_pwdata,
    input  logic              cpu_main_pready,
    input  logic [DATA_W-1:0] cpu_main_prdata,
    input  logic              cpu_main_pslverr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0] state_q;

    // Gated with rst_n so no command is taken while reset is held.
    assign cmd_ready = rst_n && (state_q == ST_IDLE);

`ifdef MIXED_APB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == ST_SETUP) begin
            cnt_q <= '0;
        end else if (state_q == ST_ACCESS && !cpu_main_pready) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The counter reaches TIMEOUT_CYCLES on the edge that ends the last allowed wait cycle.
    logic timeout;
    assign timeout = !cpu_main_pready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic timeout;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            busy             <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= '0;
            rsp_err          <= 1'b0;
            cpu_main_paddr   <= '0;
            cpu_main_psel    <= 1'b0;
            cpu_main_penable <= 1'b0;
            cpu_main_pwrite  <= 1'b0;
            cpu_main_pwdata  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cpu_main_paddr  <= cmd_addr;
                        cpu_main_pwrite <= cmd_write;
                        cpu_main_pwdata <= cmd_write ? cmd_wdata : '0;
                        cpu_main_psel   <= 1'b1;
                        busy            <= 1'b1;
                        state_q         <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cpu_main_penable <= 1'b1;
                    state_q          <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (cpu_main_pready) begin
                        rsp_rdata        <= cpu_main_pwrite ? '0 : cpu_main_prdata;
                        rsp_err          <= cpu_main_pslverr;
                        rsp_valid        <= 1'b1;
                        cpu_main_psel    <= 1'b0;
                        cpu_main_penable <= 1'b0;
                        state_q          <= ST_RESP;
                    end else if (timeout) begin
                        rsp_rdata        <= DATA_W'(32'hDEAD_BEEF);
                        rsp_err          <= 1'b1;
                        rsp_valid        <= 1'b1;
                        cpu_main_psel    <= 1'b0;
                        cpu_main_penable <= 1'b0;
                        state_q          <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mixed_apb_cmd_master.sv
// Self-checking bench for mixed_apb_cmd_master: directed plan cases plus randomized transfers.
module tb_mixed_apb_cmd_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
    logic [31:0] rsp_rdata, paddr, pwdata, prdata = '0;
    logic        psel, penable, pwrite, pready = 1'b0, pslverr = 1'b0;

    int ncomp = 0;
    int nfail = 0;

    mixed_apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .cpu_main_paddr(paddr), .cpu_main_psel(psel), .cpu_main_penable(penable),
        .cpu_main_pwrite(pwrite), .cpu_main_pwdata(pwdata), .cpu_main_pready(pready),
        .cpu_main_prdata(prdata), .cpu_main_pslverr(pslverr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        ncomp++;
        if ({cmd_ready, busy, rsp_valid, rsp_err, rsp_rdata, psel, penable, pwrite, paddr, pwdata}
            !== '0) begin
            nfail++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b rv=%b err=%b rd=%h psel=%b pen=%b pa=%h pw=%h, want all 0",
                     cmd_ready, busy, rsp_valid, rsp_err, rsp_rdata, psel, penable, paddr, pwdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ncomp++;
        if ({cmd_ready, busy} !== 2'b10) begin
            nfail++;
            $display("FAIL reset_release: got cmd_ready=%b busy=%b, want 1 0", cmd_ready, busy);
        end
    endtask

    // Reference: one transfer = SETUP, (waits+1) ACCESS cycles, RESP held for hold cycles, IDLE.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input logic err, input int waits, input int hold,
                        input string name);
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        exp_wd = wr ? wd : 32'h0;
        exp_rd = wr ? 32'h0 : rd;
        ncomp++;
        if ({cmd_ready, busy, psel, penable, rsp_valid} !== 5'b10000) begin
            nfail++;
            $display("FAIL %s idle: got rdy=%b busy=%b psel=%b pen=%b rv=%b, want 1 0 0 0 0",
                     name, cmd_ready, busy, psel, penable, rsp_valid);
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        pready = 1'($urandom);
        ncomp++;
        if ({psel, penable, cmd_ready, busy, rsp_valid, pwrite, paddr, pwdata}
            !== {5'b10010, wr, addr, exp_wd}) begin
            nfail++;
            $display("FAIL %s setup: got psel=%b pen=%b rdy=%b busy=%b rv=%b pw=%b pa=%h wd=%h, want 1 0 0 1 0 %b %h %h",
                     name, psel, penable, cmd_ready, busy, rsp_valid, pwrite, paddr, pwdata,
                     wr, addr, exp_wd);
        end
        @(negedge clk);
        for (int i = 0; i <= waits; i++) begin
            ncomp++;
            if ({psel, penable, cmd_ready, busy, rsp_valid, pwrite, paddr, pwdata}
                !== {5'b11010, wr, addr, exp_wd}) begin
                nfail++;
                $display("FAIL %s access%0d: got psel=%b pen=%b rdy=%b busy=%b rv=%b pw=%b pa=%h wd=%h, want 1 1 0 1 0 %b %h %h",
                         name, i, psel, penable, cmd_ready, busy, rsp_valid, pwrite, paddr,
                         pwdata, wr, addr, exp_wd);
            end
            pready  = (i == waits);
            prdata  = (i == waits) ? rd : $urandom;
            pslverr = (i == waits) ? err : 1'($urandom);
            @(negedge clk);
        end
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
        for (int h = 0; h <= hold; h++) begin
            ncomp++;
            if ({rsp_valid, rsp_err, rsp_rdata, psel, penable, cmd_ready, busy, paddr, pwrite, pwdata}
                !== {1'b1, err, exp_rd, 4'b0001, addr, wr, exp_wd}) begin
                nfail++;
                $display("FAIL %s resp%0d: got rv=%b err=%b rd=%h psel=%b pen=%b rdy=%b busy=%b pa=%h, want 1 %b %h 0 0 0 1 %h",
                         name, h, rsp_valid, rsp_err, rsp_rdata, psel, penable, cmd_ready, busy,
                         paddr, err, exp_rd, addr);
            end
            rsp_ready = (h == hold);
            cmd_valid = (h == hold) ? 1'b0 : 1'($urandom);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        ncomp++;
        if ({rsp_valid, busy, cmd_ready, psel, paddr} !== {4'b0010, addr}) begin
            nfail++;
            $display("FAIL %s back_idle: got rv=%b busy=%b rdy=%b psel=%b pa=%h, want 0 0 1 0 %h",
                     name, rsp_valid, busy, cmd_ready, psel, paddr, addr);
        end
    endtask

    task automatic test_write_basic();
        xfer(1'b1, 32'h0000_0010, 32'hA5A5_0001, 32'hFFFF_FFFF, 1'b0, 0, 0, "write_basic");
    endtask

    task automatic test_read_wait();
        xfer(1'b0, 32'h0000_0020, 32'h0BAD_0BAD, 32'h1234_5678, 1'b0, 3, 0, "read_wait");
    endtask

    task automatic test_slverr_hold();
        xfer(1'b0, 32'h0000_0030, 32'h0, 32'hCAFE_F00D, 1'b1, 1, 5, "slverr_hold");
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            xfer(1'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
                 int'($urandom_range(4, 0)), int'($urandom_range(3, 0)), "random");
        end
    endtask

    task automatic test_back_to_back();
        int s1 = -1;
        int s2 = -1;
        logic [31:0] a2 = 32'h0000_0200;
        logic [31:0] pa2 = '0;
        bit overlap = 1'b0;
        bit drained = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0100; cmd_wdata = 32'h1111_2222;
        rsp_ready = 1'b1; pready = 1'b1; pslverr = 1'b0;
        for (int c = 0; c < 20 && s2 < 0; c++) begin
            @(negedge clk);
            if (psel && rsp_valid) overlap = 1'b1;
            if (psel && !penable) begin
                if (s1 < 0) begin
                    s1 = c;
                    cmd_addr = a2;
                end else begin
                    s2 = c;
                    pa2 = paddr;
                    cmd_valid = 1'b0;
                end
            end
        end
        for (int c = 0; c < 10 && !drained; c++) begin
            @(negedge clk);
            if (psel && rsp_valid) overlap = 1'b1;
            if (!busy && !rsp_valid) drained = 1'b1;
        end
        rsp_ready = 1'b0; pready = 1'b0;
        ncomp++;
        if (s2 - s1 !== 4 || s1 < 0) begin
            nfail++;
            $display("FAIL b2b_spacing: got setups at %0d and %0d, want 4 cycles apart", s1, s2);
        end
        ncomp++;
        if (pa2 !== a2) begin
            nfail++;
            $display("FAIL b2b_addr2: got %h, want %h", pa2, a2);
        end
        ncomp++;
        if ({overlap, drained} !== 2'b01) begin
            nfail++;
            $display("FAIL b2b_overlap_drain: got overlap=%b drained=%b, want 0 1", overlap, drained);
        end
    endtask

    task automatic test_reset_mid_access();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0040; pready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        ncomp++;
        if ({psel, penable, rsp_valid, busy, cmd_ready, paddr} !== '0) begin
            nfail++;
            $display("FAIL reset_mid_access: got psel=%b pen=%b rv=%b busy=%b rdy=%b pa=%h, want all 0",
                     psel, penable, rsp_valid, busy, cmd_ready, paddr);
        end
        pready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ncomp++;
            if ({cmd_ready, busy, rsp_valid, psel} !== 4'b1000) begin
                nfail++;
                $display("FAIL reset_no_stale%0d: got rdy=%b busy=%b rv=%b psel=%b, want 1 0 0 0",
                         c, cmd_ready, busy, rsp_valid, psel);
            end
        end
        pready = 1'b0;
    endtask

`ifdef MIXED_APB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int n_access = 0;
        bit seen = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0050; pready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
            else if (psel && penable) n_access++;
        end
        ncomp++;
        if ({seen, rsp_err, rsp_rdata, psel, penable} !== {2'b11, 32'hDEAD_BEEF, 2'b00}
            || n_access != TO) begin
            nfail++;
            $display("FAIL timeout: got seen=%b err=%b rd=%h access_cycles=%0d, want 1 1 deadbeef %0d",
                     seen, rsp_err, rsp_rdata, n_access, TO);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_write_basic();
        test_read_wait();
        test_slverr_hold();
        test_random();
        test_back_to_back();
        test_reset_mid_access();
`ifdef MIXED_APB_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
